// File: rtl/car_pkg.sv
// car_pkg
//   Shared definitions for the car controller slice.
//   - turn_state_t : state codes of sauto_turn_ctrl (also driven onto state_dbg)
//   - DIR_LEFT/DIR_RIGHT : encoding of the dir_left input
//   - MS_W : width of the millisecond counter used by ms_timer
package car_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } turn_state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam int MS_W = 16;

endpackage

// File: rtl/sauto_turn_ctrl_ms_timer.sv
// ms_timer
//   Prescaler (0..TICK_DIV-1) feeding a millisecond counter. Both counters
//   clear on clr and hold while en is low.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-low reset
//   clr      in   synchronous clear of prescaler and ms counter (wins over en)
//   en       in   advance the prescaler this cycle
//   limit    in   ms count to reach
//   expired  out  combinational: the ms count reaches limit on this edge
module ms_timer #(
    parameter int TICK_DIV = 100_000,
    parameter int MS_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [MS_W-1:0] limit,
    output logic            expired
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]   r_presc;
    logic [MS_W-1:0] r_ms;
    logic            w_wrap;
    logic [MS_W-1:0] w_ms_next;

    assign w_wrap    = en && (r_presc == PRESC_MAX);
    assign w_ms_next = r_ms + {{(MS_W-1){1'b0}}, w_wrap};

    // Compared against the value the ms counter takes at this edge, so the
    // owning state is left on the very edge the count reaches limit rather
    // than one cycle later.
    assign expired = (w_ms_next == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (clr) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (en) begin
            if (w_wrap) begin
                r_presc <= '0;
                r_ms    <= w_ms_next;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sauto_turn_ctrl.sv
// sauto_turn_ctrl
//   Sequences one semi-auto turn at a fork: pivot toward the latched
//   direction for TURN_MS, drive forward for CLEAR_MS (paused while an
//   obstacle is ahead), then emit a one-cycle finish_turning pulse.
// Ports
//   sys_clk         in   system clock
//   rst             in   asynchronous, active-low reset
//   start           in   begin a turn (IDLE only)
//   dir_left        in   1 = left, 0 = right; sampled with start
//   abort           in   synchronous cancel back to IDLE
//   front_detector  in   1 = obstacle ahead; pauses CLEAR
//   busy            out  high in TURN, CLEAR, DONE
//   turn_left       out  pivot-left command
//   turn_right      out  pivot-right command
//   move_forward    out  forward command
//   finish_turning  out  one-cycle completion pulse
//   state_dbg       out  current state code
//
// state   | meaning
// IDLE    | waiting for start
// TURN    | pivoting toward dir_q for TURN_MS
// CLEAR   | driving forward for CLEAR_MS of unblocked time
// DONE    | single cycle, finish_turning high
module sauto_turn_ctrl
    import car_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TURN_MS  = 900,
    parameter int CLEAR_MS = 500
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir_left,
    input  logic       abort,
    input  logic       front_detector,
    output logic       busy,
    output logic       turn_left,
    output logic       turn_right,
    output logic       move_forward,
    output logic       finish_turning,
    output logic [1:0] state_dbg
);

    localparam int TICK_DIV = CLK_HZ / 1000;

    if (TURN_MS < 1 || TURN_MS > 65535) begin : g_bad_turn_ms
        $error("sauto_turn_ctrl: TURN_MS must be within 1..65535");
    end
    if (CLEAR_MS < 1 || CLEAR_MS > 65535) begin : g_bad_clear_ms
        $error("sauto_turn_ctrl: CLEAR_MS must be within 1..65535");
    end
    if (TICK_DIV < 1) begin : g_bad_clk_hz
        $error("sauto_turn_ctrl: CLK_HZ must be at least 1000");
    end

    turn_state_t     r_state;
    logic            r_dir;
    logic            r_busy;
    logic            r_turn_left;
    logic            r_turn_right;
    logic            r_move_fwd;
    logic            r_finish;

    logic            w_timed;
    logic            w_timer_en;
    logic            w_timer_clr;
    logic            w_expired;
    logic [MS_W-1:0] w_limit;

    assign w_timed     = (r_state == S_TURN) || (r_state == S_CLEAR);
    // front_detector only freezes time in CLEAR; a pivot is unaffected.
    assign w_timer_en  = (r_state == S_TURN) ||
                         ((r_state == S_CLEAR) && !front_detector);
    // Clearing on every exit edge means each timed state starts from zero.
    assign w_timer_clr = !w_timed || abort || w_expired;
    assign w_limit     = (r_state == S_TURN) ? MS_W'(TURN_MS) : MS_W'(CLEAR_MS);

    ms_timer #(
        .TICK_DIV (TICK_DIV),
        .MS_W     (MS_W)
    ) u_ms_timer (
        .clk     (sys_clk),
        .rst     (rst),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .limit   (w_limit),
        .expired (w_expired)
    );

    // Outputs are decoded from the state being entered, so they change on
    // the same edge as r_state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_dir        <= DIR_RIGHT;
            r_busy       <= 1'b0;
            r_turn_left  <= 1'b0;
            r_turn_right <= 1'b0;
            r_move_fwd   <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_busy       <= 1'b0;
            r_turn_left  <= 1'b0;
            r_turn_right <= 1'b0;
            r_move_fwd   <= 1'b0;
            r_finish     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state      <= S_TURN;
                        r_dir        <= dir_left;
                        r_busy       <= 1'b1;
                        r_turn_left  <= dir_left;
                        r_turn_right <= !dir_left;
                    end
                end
                S_TURN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_expired) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_move_fwd <= !front_detector;
                    end else begin
                        r_busy       <= 1'b1;
                        r_turn_left  <= r_dir;
                        r_turn_right <= !r_dir;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_expired) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b1;
                        r_finish <= 1'b1;
                    end else begin
                        r_busy     <= 1'b1;
                        r_move_fwd <= !front_detector;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign turn_left      = r_turn_left;
    assign turn_right     = r_turn_right;
    assign move_forward   = r_move_fwd;
    assign finish_turning = r_finish;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_sauto_turn_ctrl.sv
// Directed bench for sauto_turn_ctrl with TICK_DIV=10, TURN_MS=3, CLEAR_MS=2.
// Cycle c is the clock period after the c-th rising edge counted from the
// cycle in which start is driven (cycle 0). Outputs are sampled on the
// falling edge inside each cycle, inputs are changed there too.
module tb_sauto_turn_ctrl;

    logic       sys_clk;
    logic       rst;
    logic       start;
    logic       dir_left;
    logic       abort;
    logic       front_detector;
    logic       busy;
    logic       turn_left;
    logic       turn_right;
    logic       move_forward;
    logic       finish_turning;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // {busy, turn_left, turn_right, move_forward, finish_turning, state_dbg}
    logic [6:0] obs [0:127];

    sauto_turn_ctrl #(
        .CLK_HZ   (10_000),
        .TURN_MS  (3),
        .CLEAR_MS (2)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .start          (start),
        .dir_left       (dir_left),
        .abort          (abort),
        .front_detector (front_detector),
        .busy           (busy),
        .turn_left      (turn_left),
        .turn_right     (turn_right),
        .move_forward   (move_forward),
        .finish_turning (finish_turning),
        .state_dbg      (state_dbg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [6:0] out_vec();
        return {busy, turn_left, turn_right, move_forward, finish_turning, state_dbg};
    endfunction

    // Hand-derived timeline: TURN 1..30, CLEAR 31..50+d, DONE 51+d.
    // A front_detector block over cycles f..f+d-1 shows on the registered
    // move_forward one cycle later (f+1..f+d). abort at cycle a clears all from a+1.
    function automatic logic [6:0] exp_vec(int c, logic d, int pause, int f, int a);
        logic       b, tl, tr, mf, fin;
        logic [1:0] st;
        b = 0; tl = 0; tr = 0; mf = 0; fin = 0; st = 2'd0;
        if (a >= 0 && c > a) return 7'd0;
        if (c >= 1 && c <= 30) begin
            b = 1; tl = d; tr = !d; st = 2'd1;
        end else if (c >= 31 && c <= 50 + pause) begin
            b = 1; st = 2'd2;
            mf = !(f >= 0 && c > f && c <= f + pause);
        end else if (c == 51 + pause) begin
            b = 1; fin = 1; st = 2'd3;
        end
        return {b, tl, tr, mf, fin, st};
    endfunction

    // Drives one sequence and records outputs for cycles 0..ncyc.
    task automatic run_capture(input logic d, input int fd_from, input int fd_len,
                               input int abort_at, input int start2_at, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge sys_clk);
            obs[c]         = out_vec();
            start          = (c == 0) || (c == start2_at);
            dir_left       = (c == start2_at) ? !d : d;
            abort          = (c == abort_at);
            front_detector = (fd_from >= 0) && (c >= fd_from) && (c < fd_from + fd_len);
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
        start = 0; dir_left = 0; abort = 0; front_detector = 0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 0; dir_left = 0; abort = 0; front_detector = 0;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (out_vec() !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_held: got %b expected %b", out_vec(), 7'd0);
        end
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (out_vec() !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_released_idle: got %b expected %b", out_vec(), 7'd0);
        end
    endtask

    task automatic test_turn(input logic d);
        run_capture(d, -1, 0, -1, -1, 60);
        for (int c = 0; c <= 60; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c, d, 0, -1, -1)) begin
                n_errors++;
                $display("FAIL turn_dir%0d cycle %0d: got %b expected %b", d, c, obs[c], exp_vec(c, d, 0, -1, -1));
            end
        end
    endtask

    task automatic test_front_block();
        run_capture(1'b1, 35, 15, -1, -1, 75);
        for (int c = 0; c <= 75; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c, 1'b1, 15, 35, -1)) begin
                n_errors++;
                $display("FAIL front_block cycle %0d: got %b expected %b", c, obs[c], exp_vec(c, 1'b1, 15, 35, -1));
            end
        end
    endtask

    task automatic test_abort(input int a, input string nm);
        run_capture(1'b1, -1, 0, a, -1, 60);
        for (int c = 0; c <= 60; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c, 1'b1, 0, -1, a)) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", nm, c, obs[c], exp_vec(c, 1'b1, 0, -1, a));
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_capture(1'b1, -1, 0, -1, 5, 60);
        for (int c = 0; c <= 60; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c, 1'b1, 0, -1, -1)) begin
                n_errors++;
                $display("FAIL start_while_busy cycle %0d: got %b expected %b", c, obs[c], exp_vec(c, 1'b1, 0, -1, -1));
            end
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge sys_clk);
        start = 1; dir_left = 1; abort = 1;
        @(negedge sys_clk);
        start = 0; dir_left = 0; abort = 0;
        n_checks++;
        if (out_vec() !== 7'd0) begin
            n_errors++;
            $display("FAIL start_abort_idle: got %b expected %b", out_vec(), 7'd0);
        end
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (out_vec() !== 7'd0) begin
            n_errors++;
            $display("FAIL start_abort_stays_idle: got %b expected %b", out_vec(), 7'd0);
        end
    endtask

    task automatic test_reset_mid_turn();
        // Capture cycles 0..20; the reset lands during cycle 21, still in TURN.
        run_capture_partial();
        n_checks++;
        if (obs[20] !== exp_vec(20, 1'b1, 0, -1, -1)) begin
            n_errors++;
            $display("FAIL pre_reset_turn: got %b expected %b", obs[20], exp_vec(20, 1'b1, 0, -1, -1));
        end
        n_checks++;
        if (out_vec() !== exp_vec(21, 1'b1, 0, -1, -1)) begin
            n_errors++;
            $display("FAIL mid_turn_before_rst: got %b expected %b", out_vec(), exp_vec(21, 1'b1, 0, -1, -1));
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== 7'd0) begin
            n_errors++;
            $display("FAIL async_reset_clear: got %b expected %b", out_vec(), 7'd0);
        end
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        run_capture(1'b1, -1, 0, -1, -1, 60);
        for (int c = 0; c <= 60; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c, 1'b1, 0, -1, -1)) begin
                n_errors++;
                $display("FAIL after_reset cycle %0d: got %b expected %b", c, obs[c], exp_vec(c, 1'b1, 0, -1, -1));
            end
        end
    endtask

    // Starts a left turn and stops driving at the falling edge of cycle 21.
    task automatic run_capture_partial();
        for (int c = 0; c <= 20; c++) begin
            @(negedge sys_clk);
            obs[c]   = out_vec();
            start    = (c == 0);
            dir_left = 1'b1;
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
        start = 0; dir_left = 0;
    endtask

    initial begin
        test_reset();
        test_turn(1'b1);
        test_turn(1'b0);
        test_front_block();
        test_abort(10, "abort_in_turn");
        test_abort(40, "abort_in_clear");
        test_abort(51, "abort_in_done");
        test_start_while_busy();
        test_start_abort_idle();
        test_reset_mid_turn();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
